des_subkey_gen: RTL

DES_SUBKEY_GEN -- requirements
Module: des_subkey_gen

---
 rtl/des_pkg.sv | 80 ++++++++
 rtl/des_pc2.sv | 19 +
 rtl/des_subkey_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// des_pkg -- shared constants and helpers for the DES key schedule.
//   PC1_TABLE   : 56 FIPS bit numbers (1..64) selecting C0||D0 from the key
//   PC2_TABLE   : 48 FIPS bit numbers (1..56) selecting a subkey from C||D
//   SHIFT_TABLE : left-rotation amount for each of the 16 rounds
//   state_e     : subkey generator FSM states
// Bit convention for all vectors here: [N-1:0] with the MSB holding FIPS bit 1.
package des_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [5:0] PC1_TABLE [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2_TABLE [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  localparam logic [1:0] SHIFT_TABLE [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // PC-1: parity bits (8,16,...,64) are never referenced by the table.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = 56'd0;
    for (int i = 0; i < 56; i++) begin
      r[55 - i] = k[64 - int'(PC1_TABLE[i])];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] r;
    case (n)
      2'd1:    r = {x[26:0], x[27]};
      2'd2:    r = {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] r;
    case (n)
      2'd1:    r = {x[0], x[27:1]};
      2'd2:    r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  // C and D halves always rotate by the same amount.
  function automatic logic [55:0] cd_rotl(input logic [55:0] cd, input logic [1:0] n);
    return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
  endfunction

  function automatic logic [55:0] cd_rotr(input logic [55:0] cd, input logic [1:0] n);
    return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// des_pc2 -- combinational PC-2 permutation.
//   cd_i     : C||D, 56 bits, MSB = FIPS bit 1
//   subkey_o : 48-bit subkey, MSB = FIPS bit 1
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] subkey_o
);

  // Select the 48 subkey bits from C||D.
  always_comb begin
    subkey_o = 48'd0;
    for (int i = 0; i < 48; i++) begin
      subkey_o[47 - i] = cd_i[56 - int'(PC2_TABLE[i])];
    end
  end

endmodule

// File: rtl/des_subkey_gen.sv
// des_subkey_gen -- emits the 16 DES round subkeys for one key, one per
// handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
//   clk, rst                 : clock, asynchronous active-high reset
//   key_valid/key_ready      : key intake handshake (ready only in IDLE)
//   key [0:63], decrypt      : key in FIPS order and direction, sampled together
//   subkey_valid/subkey_ready: subkey output handshake
//   subkey [0:47]            : registered PC-2 output in FIPS order
//   round [3:0], last        : emission index, high on index 15
// CLEAR_ON_DONE = 1 wipes the C/D registers once the last subkey is taken.
module des_subkey_gen
  import des_pkg::*;
#(
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [0:63] key,
  input  logic        decrypt,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [0:47] subkey,
  output logic [3:0]  round,
  output logic        last
);

  state_e      state_q;
  logic [55:0] cd_q;
  logic [55:0] cd_d;
  logic        mode_q;
  logic [3:0]  round_q;
  logic        last_q;
  logic        valid_q;
  logic [47:0] subkey_q;
  logic [47:0] subkey_d;
  logic [63:0] key_s;

  assign key_s        = key;
  assign key_ready    = (state_q == ST_IDLE);
  assign subkey_valid = valid_q;
  assign subkey       = subkey_q;
  assign round        = round_q;
  assign last         = last_q;

  // cd_q always holds the C||D that produced the subkey currently on the
  // output. In IDLE the next value is the first emission of the offered key;
  // in RUN it is the following emission (right rotation walks back from C16,
  // which equals C0 because the schedule sums to 28).
  always_comb begin
    cd_d = cd_q;
    if (state_q == ST_IDLE) begin
      if (decrypt) begin
        cd_d = pc1(key_s);
      end else begin
        cd_d = cd_rotl(pc1(key_s), SHIFT_TABLE[4'd0]);
      end
    end else begin
      if (mode_q) begin
        cd_d = cd_rotr(cd_q, SHIFT_TABLE[4'd15 - round_q]);
      end else begin
        cd_d = cd_rotl(cd_q, SHIFT_TABLE[round_q + 4'd1]);
      end
    end
  end

  des_pc2 u_pc2 (
    .cd_i     (cd_d),
    .subkey_o (subkey_d)
  );

  // Control FSM plus all registered datapath state and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cd_q     <= 56'd0;
      mode_q   <= 1'b0;
      round_q  <= 4'd0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      subkey_q <= 48'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            cd_q     <= cd_d;
            mode_q   <= decrypt;
            subkey_q <= subkey_d;
            round_q  <= 4'd0;
            last_q   <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (valid_q && subkey_ready) begin
            if (round_q == 4'd15) begin
              state_q  <= ST_IDLE;
              valid_q  <= 1'b0;
              last_q   <= 1'b0;
              round_q  <= 4'd0;
              subkey_q <= 48'd0;
              if (CLEAR_ON_DONE) begin
                cd_q <= 56'd0;
              end else begin
                cd_q <= cd_q;
              end
            end else begin
              cd_q     <= cd_d;
              subkey_q <= subkey_d;
              round_q  <= round_q + 4'd1;
              last_q   <= (round_q == 4'd14);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
